// File: rtl/axis_reg_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream register FIFO.
// Optional feature macro: REG_FIFO_TLAST_EN (adds a tlast sideband bit).
package reg_fifo_pkg;

  // Fill state of the FIFO, decoded from the occupancy count.
  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fill_state_e;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_reg_fifo_if.sv
// AXI-Stream handshake bundle used on both sides of the register FIFO.
// Optional feature macro: REG_FIFO_TLAST_EN (adds the tlast signal).
interface axis_reg_fifo_if #(
  parameter int DWIDTH = 32
) ();

  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tready;
`ifdef REG_FIFO_TLAST_EN
  logic              tlast;
`endif

`ifdef REG_FIFO_TLAST_EN
  // Source of beats: drives payload/valid/last, observes ready.
  modport master (output tdata, output tvalid, output tlast, input tready);
  // Sink of beats: observes payload/valid/last, drives ready.
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
  // Source of beats: drives payload/valid, observes ready.
  modport master (output tdata, output tvalid, input tready);
  // Sink of beats: observes payload/valid, drives ready.
  modport slave  (input tdata, input tvalid, output tready);
`endif

endinterface

// File: rtl/axis_reg_fifo_ptr.sv
// Modulo write/read pointer pair plus occupancy counter for the register FIFO.
// DEPTH is a power of two, so the pointers wrap by natural overflow.
module reg_fifo_ptr
  import reg_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_nxt
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;

  // Next pointers and occupancy from the push/pop strobes.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (inc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (dec) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({inc, dec})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/axis_reg_fifo.sv
// DEPTH-entry AXI-Stream register FIFO with registered ready/valid,
// occupancy output and almost-full flag. Storage is a flop array.
// Optional feature macro: REG_FIFO_TLAST_EN (stores tlast with each beat).
module axis_reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter  int DWIDTH       = 32,
  parameter  int DEPTH        = 4,
  parameter  int AFULL_THRESH = DEPTH - 1,
  localparam int LVL_W        = lvl_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  axis_reg_fifo_if.slave   s_in,
  axis_reg_fifo_if.master  m_out,
  output logic [LVL_W-1:0] level,
  output logic             almost_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef REG_FIFO_TLAST_EN
  localparam int ENTRY_W = DWIDTH + 1;
`else
  localparam int ENTRY_W = DWIDTH;
`endif

  logic               push, pop;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_nxt;
  logic [ENTRY_W-1:0] wr_entry, head;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  fill_state_e fill_nxt;
  logic        tready_q, tready_d;
  logic        tvalid_q, tvalid_d;
  logic        afull_q,  afull_d;

  // Handshakes use only registered flags, so no input reaches an output combinationally.
  assign push = s_in.tvalid & tready_q;
  assign pop  = tvalid_q & m_out.tready;

`ifdef REG_FIFO_TLAST_EN
  assign wr_entry = {s_in.tlast, s_in.tdata};
`else
  assign wr_entry = s_in.tdata;
`endif

  reg_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .inc       (push),
    .dec       (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .level     (level),
    .level_nxt (level_nxt)
  );

  // Write the incoming beat into the slot at the write pointer.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = wr_entry;
  end

  // Storage flops.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the array is reset so a post-reset head read is a defined zero, not stale data.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Decode the fill state the FIFO will be in after this edge.
  always_comb begin
    fill_nxt = PARTIAL;
    if (level_nxt == '0)                fill_nxt = EMPTY;
    else if (level_nxt == LVL_W'(DEPTH)) fill_nxt = FULL;
  end

  // Flag values for the next cycle, derived from the next fill state.
  always_comb begin
    tready_d = (fill_nxt != FULL);
    tvalid_d = (fill_nxt != EMPTY);
    afull_d  = (level_nxt >= LVL_W'(AFULL_THRESH));
  end

  // Flag registers; ready stays low during reset and rises on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      afull_q  <= afull_d;
    end
  end

  // Head of FIFO is a plain mux of the storage flops.
  assign head         = mem_q[rd_ptr];
  assign m_out.tdata  = head[DWIDTH-1:0];
`ifdef REG_FIFO_TLAST_EN
  assign m_out.tlast  = head[DWIDTH];
`endif
  assign m_out.tvalid = tvalid_q;
  assign s_in.tready  = tready_q;
  assign almost_full  = afull_q;

endmodule

// File: tb/tb_axis_reg_fifo.sv
// Directed testbench for axis_reg_fifo (DWIDTH=32, DEPTH=4, AFULL_THRESH=3).
module tb_axis_reg_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [LVL_W-1:0] level;
  logic             almost_full;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mdl_q[$];
  int            mdl_level = 0;

  axis_reg_fifo_if #(.DWIDTH(DW)) s_in_if ();
  axis_reg_fifo_if #(.DWIDTH(DW)) m_out_if ();

  axis_reg_fifo #(
    .DWIDTH       (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in        (s_in_if),
    .m_out       (m_out_if),
    .level       (level),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of model-checked traffic; inputs are applied mid-cycle.
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr,
                       output logic pushed, output logic popped);
    logic push, pop;
    s_in_if.tvalid  = sv;
    s_in_if.tdata   = sd;
    m_out_if.tready = mr;
    push = sv && (mdl_level != DEPTH);
    pop  = mr && (mdl_level != 0);
    if (mdl_q.size() > 0) check("head_data", m_out_if.tdata, mdl_q[0]);
    popped = m_out_if.tvalid && mr;
    pushed = push;
    @(posedge clk); #1;
    if (pop)  void'(mdl_q.pop_front());
    if (push) mdl_q.push_back(sd);
    mdl_level = mdl_q.size();
    check("level", 32'(level), 32'(mdl_level));
    check("s_tready", 32'(s_in_if.tready), 32'(mdl_level != DEPTH));
    check("m_tvalid", 32'(m_out_if.tvalid), 32'(mdl_level != 0));
    check("almost_full", 32'(almost_full), 32'(mdl_level >= 3));
  endtask

  initial begin
    logic pu, po;
    int   npush, npop, ncyc;
    logic [DW-1:0] exp_data [4];

    rst = 1'b1;
    s_in_if.tvalid  = 1'b0;
    s_in_if.tdata   = '0;
    m_out_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 32'(s_in_if.tready), 0);
    check("rst_tvalid", 32'(m_out_if.tvalid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_afull", 32'(almost_full), 0);

    // Release reset mid-cycle; ready must wait for the next edge.
    rst = 1'b0;
    #1;
    check("rel_tready_before_edge", 32'(s_in_if.tready), 0);
    @(posedge clk); #1;
    check("rel_tready_after_edge", 32'(s_in_if.tready), 1);
    check("rel_tvalid", 32'(m_out_if.tvalid), 0);
    check("rel_level", 32'(level), 0);

    // Fill with 0x11..0x44 while downstream stalls.
    exp_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      s_in_if.tvalid = 1'b1;
      s_in_if.tdata  = exp_data[i];
      @(posedge clk); #1;
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_afull", 32'(almost_full), 32'(i >= 2));
      check("fill_tready", 32'(s_in_if.tready), 32'(i < 3));
      check("fill_tvalid", 32'(m_out_if.tvalid), 1);
      check("fill_head", m_out_if.tdata, 32'h11);
    end
    s_in_if.tvalid = 1'b0;

    // Drain four beats in order.
    m_out_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_tvalid", 32'(m_out_if.tvalid), 1);
      check("drain_data", m_out_if.tdata, exp_data[i]);
      @(posedge clk); #1;
      check("drain_tready", 32'(s_in_if.tready), 1);
      check("drain_level", 32'(level), 32'(3 - i));
    end
    check("drain_empty_tvalid", 32'(m_out_if.tvalid), 0);
    check("drain_empty_afull", 32'(almost_full), 0);

    // Continuous streaming: level sits at 1, one beat per cycle after the first.
    npop = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 32'h1000 + 32'(i), 1'b1, pu, po);
      if (po) npop++;
      if (i > 0) check("stream_level1", 32'(level), 1);
    end
    check("stream_throughput", 32'(npop), 99);
    for (int k = 0; k < 10 && mdl_q.size() > 0; k++) cycle(1'b0, '0, 1'b1, pu, po);
    check("stream_drained", 32'(m_out_if.tvalid), 0);

    // Random 50% valid/ready, 10k accepted beats, bounded by a cycle budget.
    npush = 0;
    ncyc  = 0;
    while (npush < 10000 && ncyc < 60000) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), pu, po);
      if (pu) npush++;
      ncyc++;
      if (level > LVL_W'(DEPTH)) check("rand_level_bound", 32'(level), DEPTH);
    end
    check("rand_beats_done", 32'(npush), 10000);
    for (int k = 0; k < 10 && mdl_q.size() > 0; k++) cycle(1'b0, '0, 1'b1, pu, po);
    check("rand_drained", 32'(m_out_if.tvalid), 0);

    // Reset mid-operation at level 3; contents discarded asynchronously.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h55 + 32'(i), 1'b0, pu, po);
    check("pre_rst_level", 32'(level), 3);
    s_in_if.tvalid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(m_out_if.tvalid), 0);
    check("arst_tready", 32'(s_in_if.tready), 0);
    check("arst_level", 32'(level), 0);
    check("arst_afull", 32'(almost_full), 0);
    check("arst_tdata", m_out_if.tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_q.delete();
    mdl_level = 0;
    @(posedge clk); #1;
    check("rerel_tready", 32'(s_in_if.tready), 1);
    check("rerel_tvalid", 32'(m_out_if.tvalid), 0);
    cycle(1'b1, 32'hAA, 1'b0, pu, po);
    check("post_rst_first", m_out_if.tdata, 32'hAA);
    cycle(1'b0, '0, 1'b1, pu, po);
    check("post_rst_popped", 32'(po), 1);
    check("post_rst_empty", 32'(m_out_if.tvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
